// File: rtl/wb_ext_sram_slave.sv
// wb_ext_sram_slave: Wishbone B3 SRAM slave with classic/incrementing bursts and programmable wait states.
module wb_ext_sram_slave #(
  parameter int          MEM_SIZE_BYTES = 65536,
  parameter logic [31:0] BASE_ADDR      = 32'h0000_0000,
  parameter int          WAIT_STATES    = 0,
  parameter string       MEM_FILE       = ""
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] wb_adr_i,
  input  logic        wb_cyc_i,
  input  logic        wb_stb_i,
  input  logic        wb_we_i,
  input  logic [3:0]  wb_sel_i,
  input  logic [31:0] wb_dat_i,
  input  logic        wb_cab_i,
  input  logic [2:0]  wb_cti_i,
  input  logic [1:0]  wb_bte_i,
  output logic        wb_ack_o,
  output logic        wb_rty_o,
  output logic        wb_err_o,
  output logic [31:0] wb_dat_o
);
  localparam int AW = $clog2(MEM_SIZE_BYTES) - 2;
  localparam logic [1:0] IDLE = 2'd0, WAIT = 2'd1, XFER = 2'd2;
  logic [1:0]  state_q, state_d;
  logic [29:0] addr_q, addr_d, addr_nxt;
  logic [3:0]  wcnt_q, wcnt_d;
  logic        turn_q, turn_d;
  logic [31:0] off;
  logic        hit, in_range;
  logic        unused;
  logic [31:0] mem [2**AW];
  assign off = {addr_q, 2'b00} - BASE_ADDR;
  assign hit = (state_q == XFER) & wb_cyc_i & wb_stb_i;
`ifdef WB_EXT_SRAM_RANGE_CHECK_EN
  assign in_range = off < 32'(MEM_SIZE_BYTES);
`else
  assign in_range = 1'b1;
`endif
  assign wb_ack_o = hit & in_range;
  assign wb_err_o = hit & ~in_range;
  assign wb_rty_o = 1'b0;
  assign wb_dat_o = wb_ack_o ? mem[off[AW+1:2]] : 32'h0;
  assign unused   = ^{wb_cab_i, wb_adr_i[1:0], off};
  assign addr_nxt = wb_bte_i == 2'b01 ? {addr_q[29:2], addr_q[1:0] + 2'd1} :
                    wb_bte_i == 2'b10 ? {addr_q[29:3], addr_q[2:0] + 3'd1} :
                    wb_bte_i == 2'b11 ? {addr_q[29:4], addr_q[3:0] + 4'd1} :
                                        addr_q + 30'd1;
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    wcnt_d  = wcnt_q;
    turn_d  = 1'b0;
    case (state_q)
      IDLE: if (wb_cyc_i & wb_stb_i & ~turn_q) begin
        addr_d  = wb_adr_i[31:2];
        wcnt_d  = 4'(WAIT_STATES);
        state_d = WAIT_STATES == 0 ? XFER : WAIT;
      end
      WAIT: begin
        wcnt_d  = wcnt_q - 4'd1;
        state_d = ~wb_cyc_i ? IDLE : wcnt_q == 4'd1 ? XFER : WAIT;
      end
      XFER: if (~wb_cyc_i) begin
        state_d = IDLE;
        turn_d  = 1'b1;
      end else if (hit) begin
        addr_d  = wb_cti_i == 3'b010 ? addr_nxt : addr_q;
        state_d = wb_cti_i == 3'b010 ? XFER : IDLE;
        turn_d  = wb_cti_i != 3'b010;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      addr_q  <= '0;
      wcnt_q  <= '0;
      turn_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      wcnt_q  <= wcnt_d;
      turn_q  <= turn_d;
    end
  end
  always_ff @(posedge clk)
    if (!rst && wb_ack_o && wb_we_i)
      for (int k = 0; k < 4; k++)
        if (wb_sel_i[k]) mem[off[AW+1:2]][8*k +: 8] <= wb_dat_i[8*k +: 8];
endmodule

// File: tb/tb_wb_ext_sram_slave.sv
// tb_wb_ext_sram_slave: two slaves (no wait states at base 0; 3 wait states at 0x1000_0000)
// driven by directed and random Wishbone cycles, checked against a word-array memory model.
module tb_wb_ext_sram_slave;
  localparam logic [31:0] BASE [2] = '{32'h0000_0000, 32'h1000_0000};
  localparam int WSV [2] = '{0, 3};
  logic clk = 1'b0, rst = 1'b1;
  logic        cyc [2], stb [2], we [2], ack [2], err [2], rty [2];
  logic [31:0] adr [2], dat_i [2], dato [2];
  logic [3:0]  sel [2];
  logic [2:0]  cti [2];
  logic [1:0]  bte [2];
  logic [31:0] mdl [2][16384];
  int checks = 0, errors = 0;
  always #5 clk = ~clk;

  wb_ext_sram_slave #(.MEM_SIZE_BYTES(65536), .BASE_ADDR(32'h0000_0000), .WAIT_STATES(0)) u0 (
    .clk(clk), .rst(rst), .wb_adr_i(adr[0]), .wb_cyc_i(cyc[0]), .wb_stb_i(stb[0]), .wb_we_i(we[0]),
    .wb_sel_i(sel[0]), .wb_dat_i(dat_i[0]), .wb_cab_i(1'b0), .wb_cti_i(cti[0]), .wb_bte_i(bte[0]),
    .wb_ack_o(ack[0]), .wb_rty_o(rty[0]), .wb_err_o(err[0]), .wb_dat_o(dato[0]));
  wb_ext_sram_slave #(.MEM_SIZE_BYTES(65536), .BASE_ADDR(32'h1000_0000), .WAIT_STATES(3)) u1 (
    .clk(clk), .rst(rst), .wb_adr_i(adr[1]), .wb_cyc_i(cyc[1]), .wb_stb_i(stb[1]), .wb_we_i(we[1]),
    .wb_sel_i(sel[1]), .wb_dat_i(dat_i[1]), .wb_cab_i(1'b0), .wb_cti_i(cti[1]), .wb_bte_i(bte[1]),
    .wb_ack_o(ack[1]), .wb_rty_o(rty[1]), .wb_err_o(err[1]), .wb_dat_o(dato[1]));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // word address of beat i: linear counts up, wrapN cycles inside its aligned N-word block
  function automatic logic [29:0] beat_addr(input logic [29:0] a0, input logic [1:0] b, input int i);
    logic [29:0] m;
    if (b == 2'b00) return a0 + 30'(i);
    m = 30'((4 << (b - 1)) - 1);
    return (a0 & ~m) | ((a0 + 30'(i)) & m);
  endfunction

  task automatic bus(input int d, input bit w, input logic [31:0] a, input int n, input logic [1:0] b,
                     input logic [3:0] s, input logic [31:0] wd, input int stop, output logic [31:0] rd);
    logic [29:0] wa;
    logic [31:0] v, off;
    bit inr, ea, ee;
    int lat;
    rd = '0;
    @(posedge clk); #1;
    for (int i = 0; i < n && i < stop; i++) begin
      wa = beat_addr(a[31:2], b, i);
      v = (i == 0) ? wd : $urandom;
      cyc[d] = 1'b1; stb[d] = 1'b1; we[d] = w; sel[d] = s; bte[d] = b;
      adr[d] = {wa, 2'b00}; dat_i[d] = v;
      cti[d] = (n == 1) ? 3'b000 : (i == n - 1) ? 3'b111 : 3'b010;
      lat = 0;
      @(negedge clk);
      while (!(ack[d] | err[d]) && lat < 40) begin
        @(posedge clk); #1; lat++;
        @(negedge clk);
      end
      chk($sformatf("latency d%0d beat%0d", d, i), 32'(lat), 32'((i == 0) ? WSV[d] + 1 : 0));
      if (lat >= 40) break;
      off = {wa, 2'b00} - BASE[d];
      inr = off < 32'd65536;
`ifdef WB_EXT_SRAM_RANGE_CHECK_EN
      ea = inr; ee = !inr;
`else
      ea = 1'b1; ee = 1'b0;
`endif
      chk($sformatf("resp d%0d a%h", d, {wa, 2'b00}), {30'b0, ack[d], err[d]}, {30'b0, ea, ee});
      if (!w) chk($sformatf("rdata d%0d a%h", d, {wa, 2'b00}), dato[d], ea ? mdl[d][off[15:2]] : 32'h0);
      rd = dato[d];
      if (w && ea)
        for (int k = 0; k < 4; k++)
          if (s[k]) mdl[d][off[15:2]][8*k +: 8] = v[8*k +: 8];
      @(posedge clk); #1;
    end
    cyc[d] = 1'b0; stb[d] = 1'b0; cti[d] = 3'b000;
    if (stop < n)
      repeat (3) begin
        @(negedge clk);
        chk($sformatf("abort_noack d%0d", d), 32'(ack[d]), 32'h0);
      end
  endtask

  initial begin
    logic [31:0] rd, old;
    int n, sw, d;
    logic [1:0] b;
    for (int i = 0; i < 2; i++) begin
      cyc[i] = 0; stb[i] = 0; we[i] = 0; adr[i] = '0; dat_i[i] = '0; sel[i] = '0; cti[i] = '0; bte[i] = '0;
    end
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      chk("reset_ack", 32'(ack[i]), 32'h0);
      chk("reset_err", 32'(err[i]), 32'h0);
      chk("reset_rty", 32'(rty[i]), 32'h0);
      chk("reset_dat", dato[i], 32'h0);
    end
    for (int i = 0; i < 2; i++)
      for (int k = 0; k < 4; k++)
        bus(i, 1, BASE[i] + 32'(k * 64), 16, 2'b00, 4'hF, $urandom, 16, rd);
    bus(0, 1, 32'h10, 1, 2'b00, 4'hF, 32'hDEADBEEF, 1, rd);
    bus(0, 0, 32'h10, 1, 2'b00, 4'hF, 32'h0, 1, rd);
    chk("classic_read", rd, 32'hDEADBEEF);
    bus(0, 1, 32'h10, 1, 2'b00, 4'b0101, 32'h11223344, 1, rd);
    bus(0, 0, 32'h10, 1, 2'b00, 4'hF, 32'h0, 1, rd);
    chk("byte_lanes", rd, 32'hDE22BE44);
    bus(0, 0, 32'h0C, 4, 2'b01, 4'hF, 32'h0, 4, rd);
    bus(0, 0, 32'h0C, 4, 2'b00, 4'hF, 32'h0, 4, rd);
    bus(1, 0, 32'h1000_0010, 1, 2'b00, 4'hF, 32'h0, 1, rd);
    bus(1, 0, 32'h1000_0020, 4, 2'b00, 4'hF, 32'h0, 4, rd);
    bus(1, 1, 32'h1000_0034, 8, 2'b10, 4'hF, $urandom, 8, rd);
    bus(1, 0, 32'h1000_0020, 8, 2'b10, 4'hF, 32'h0, 8, rd);
    // back-to-back request held after ack must not be acked in the turnaround cycle
    @(posedge clk); #1;
    cyc[0] = 1; stb[0] = 1; we[0] = 0; adr[0] = 32'h10; cti[0] = 3'b000; bte[0] = 2'b00;
    @(posedge clk); @(negedge clk);
    chk("turn_first_ack", 32'(ack[0]), 32'h1);
    @(posedge clk); @(negedge clk);
    chk("turn_no_ack", 32'(ack[0]), 32'h0);
    chk("turn_dat_zero", dato[0], 32'h0);
    cyc[0] = 0; stb[0] = 0;
    bus(0, 1, 32'h80, 8, 2'b00, 4'hF, $urandom, 2, rd);
    bus(0, 0, 32'h80, 8, 2'b00, 4'hF, 32'h0, 8, rd);
    @(posedge clk); #1;
    cyc[0] = 1; stb[0] = 1; we[0] = 1; sel[0] = 4'hF; adr[0] = 32'h14; dat_i[0] = 32'hA5A5_5A5A; cti[0] = 3'b000;
    @(posedge clk); #1;
    rst = 1'b1;
    @(negedge clk);
    chk("pre_rst_ack", 32'(ack[0]), 32'h1);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_ack", 32'(ack[0]), 32'h0);
    cyc[0] = 0; stb[0] = 0; we[0] = 0;
    bus(0, 0, 32'h14, 1, 2'b00, 4'hF, 32'h0, 1, rd);
    old = mdl[1][0];
    bus(1, 1, 32'h1001_0000, 1, 2'b00, 4'hF, 32'hCAFEF00D, 1, rd);
    bus(1, 0, 32'h1000_0000, 1, 2'b00, 4'hF, 32'h0, 1, rd);
`ifdef WB_EXT_SRAM_RANGE_CHECK_EN
    chk("range_unchanged", rd, old);
`else
    chk("range_alias", rd, 32'hCAFEF00D);
`endif
    bus(1, 0, 32'h1001_0000, 1, 2'b00, 4'hF, 32'h0, 1, rd);
    for (int t = 0; t < 24; t++) begin
      d = t % 2;
      n = $urandom_range(1, 8);
      b = 2'($urandom_range(0, 3));
      sw = (b == 2'b00) ? $urandom_range(0, 64 - n) : $urandom_range(0, 63);
      bus(d, 1'($urandom_range(0, 1)), BASE[d] + 32'(sw * 4), n, b, 4'($urandom_range(0, 15)), $urandom, n, rd);
    end
    for (int i = 0; i < 2; i++)
      for (int k = 0; k < 4; k++)
        bus(i, 0, BASE[i] + 32'(k * 64), 16, 2'b00, 4'hF, 32'h0, 16, rd);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end
endmodule
